// File: rtl/sys_pkg.sv
// Shared constants and FSM state encoding for the PE result collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sys_pkg;
    localparam int DATA_W    = 16;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_FIN     = 2'd3
    } state_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/res_fifo.sv
// Synchronous circular result buffer with full/empty flags and occupancy count.
// Latency: write at edge t is visible at the head from t+1; head is read combinationally.
// Backpressure: writes to a full buffer are accepted only alongside a same-cycle read.
module res_fifo
    import sys_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/pe_result_collector.sv
// Collects a programmed number of PE sum-end results into a FIFO for the host; optional sat tracking via COLLECTOR_SAT_TRACK_EN.
// Latency: se at cycle t shows rd_valid at t+1 on an empty buffer; done pulses the cycle after the buffer drains.
// Backpressure: host pops with rd_valid & rd_ready; a push into a full buffer without a pop is dropped and flags ovf.
module pe_result_collector
    import sys_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    res_num,
    input  logic                se,
    input  logic signed [DATA_W-1:0] s_out,
    input  logic                sat,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                busy,
    output logic                done,
    output logic                ovf
`ifdef COLLECTOR_SAT_TRACK_EN
    ,
    output logic                rd_sat,
    output logic                sat_flag
`endif
);
`ifdef COLLECTOR_SAT_TRACK_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam int CW = occ_w(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   remaining;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic               push_req;
    logic               accept_start;
    logic               drop;

    assign accept_start = start && (state == ST_IDLE);
    assign push_req     = se && (state == ST_COLLECT);
    // Full implies non-empty, so rd_ready alone means a pop frees a slot this cycle.
    assign drop         = push_req && fifo_full && !rd_ready;

`ifdef COLLECTOR_SAT_TRACK_EN
    assign wr_entry = {sat, s_out};
    assign rd_sat   = head[DATA_W];
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign wr_entry   = s_out;
`endif

    res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_req),
        .wr_data (wr_entry),
        .rd_en   (rd_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_data  = head[DATA_W-1:0];
    assign rd_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (res_num != '0) ? ST_COLLECT : ST_FIN;
            end
            ST_COLLECT: begin
                if (se && remaining == CNT_W'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_count == '0 || (fifo_count == CW'(1) && rd_ready))
                    state_nxt = ST_FIN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        busy = (state != ST_IDLE);
        done = (state == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            ovf       <= 1'b0;
        end else begin
            if (accept_start) begin
                remaining <= res_num;
                ovf       <= 1'b0;
            end else if (push_req) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (drop) ovf <= 1'b1;
        end
    end

`ifdef COLLECTOR_SAT_TRACK_EN
    always_ff @(posedge clk) begin
        if (rst)                                  sat_flag <= 1'b0;
        else if (accept_start)                    sat_flag <= 1'b0;
        else if (push_req && !drop && sat)        sat_flag <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_pe_result_collector.sv
// Randomized scoreboard bench for pe_result_collector against a queue-based behavioural model.
module tb_pe_result_collector;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  res_num;
    logic        se;
    logic [15:0] s_out;
    logic        sat;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic        ovf;
`ifdef COLLECTOR_SAT_TRACK_EN
    logic        rd_sat;
    logic        sat_flag;
`endif

    pe_result_collector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .res_num  (res_num),
        .se       (se),
        .s_out    (s_out),
        .sat      (sat),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
`ifdef COLLECTOR_SAT_TRACK_EN
        ,
        .rd_sat   (rd_sat),
        .sat_flag (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_e;
    int          m_count = 0;
    int          m_phase = 0;   // 0 idle, 1 collecting, 2 draining, 3 finished
    int          m_rem   = 0;
    bit          m_ovf   = 0;
    bit          m_satf  = 0;
    bit          chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares observable state and pops the scoreboard on each host handshake.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("rd_valid", 32'(rd_valid), 32'(m_count != 0));
            check("busy",     32'(busy),     32'(m_phase != 0));
            check("done",     32'(done),     32'(m_phase == 3));
            check("ovf",      32'(ovf),      32'(m_ovf));
`ifdef COLLECTOR_SAT_TRACK_EN
            check("sat_flag", 32'(sat_flag), 32'(m_satf));
`endif
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow: got data %0h expected no entry at %0t", rd_data, $time);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(exp_e[15:0]));
`ifdef COLLECTOR_SAT_TRACK_EN
                    check("rd_sat", 32'(rd_sat), 32'(exp_e[16]));
`endif
                end
            end
        end
    end

    // Driver: applies one cycle of inputs and advances the reference model across the edge.
    task automatic step(input bit i_rst, input bit i_start, input int i_num, input bit i_se,
                        input logic [15:0] i_d, input bit i_sat, input bit i_rdy);
        int n_count, n_phase, n_rem;
        bit n_ovf, n_satf, pop, push;
        rst = i_rst; start = i_start; res_num = i_num[7:0]; se = i_se;
        s_out = i_d; sat = i_sat; rd_ready = i_rdy;
        n_count = m_count; n_phase = m_phase; n_rem = m_rem; n_ovf = m_ovf; n_satf = m_satf;
        if (i_rst) begin
            exp_q.delete();
            n_count = 0; n_phase = 0; n_rem = 0; n_ovf = 0; n_satf = 0;
        end else begin
            pop     = (m_count > 0) && i_rdy;
            push    = i_se && (m_phase == 1);
            n_count = m_count - int'(pop);
            case (m_phase)
                0: if (i_start) begin
                    n_ovf = 0; n_satf = 0;
                    if ((i_num & 255) != 0) begin n_phase = 1; n_rem = i_num & 255; end
                    else n_phase = 3;
                end
                1: if (push) begin
                    n_rem = m_rem - 1;
                    if (m_count < DEPTH || pop) begin
                        exp_q.push_back({i_sat, i_d});
                        n_count++;
                        if (i_sat) n_satf = 1;
                    end else n_ovf = 1;
                    if (n_rem == 0) n_phase = 2;
                end
                2: if (n_count == 0) n_phase = 3;
                default: n_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        m_count = n_count; m_phase = n_phase; m_rem = n_rem; m_ovf = n_ovf; m_satf = n_satf;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, 0, rdy);
    endtask

    task automatic push_one(input logic [15:0] d, input bit s, input bit rdy);
        step(0, 0, 0, 1, d, s, rdy);
    endtask

    initial begin
        step(1, 0, 0, 0, 16'h0, 0, 0);
        step(1, 0, 0, 0, 16'h0, 0, 0);
        chk_en = 1;
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Three results with gaps, host always ready.
        step(0, 1, 3, 0, 16'h0, 0, 1);
        idle(1, 1);
        push_one(16'd5, 0, 1);
        idle(1, 1);
        push_one(16'hFFF9, 0, 1);
        idle(1, 1);
        push_one(16'd100, 0, 1);
        idle(1, 4);
        check("busy_after_run", 32'(busy), 32'h0);

        // Overflow: ten results into an eight-entry buffer with no pops.
        step(0, 1, 10, 0, 16'h0, 0, 0);
        for (int i = 0; i < 10; i++) push_one(16'($urandom), 0, 0);
        check("ovf_sticky", 32'(ovf), 32'h1);
        idle(0, 2);
        idle(1, 12);

        // Full buffer with simultaneous push and pop.
        step(0, 1, 9, 0, 16'h0, 0, 0);
        for (int i = 0; i < 8; i++) push_one(16'(i + 16'h40), 0, 0);
        push_one(16'h1234, 0, 1);
        check("ovf_push_pop_full", 32'(ovf), 32'h0);
        idle(1, 12);

        // Zero-length run, then strobes while idle.
        step(0, 1, 0, 0, 16'h0, 0, 0);
        idle(0, 3);
        for (int i = 0; i < 3; i++) push_one(16'hBEEF, 1, 0);
        check("idle_se_no_valid", 32'(rd_valid), 32'h0);

        // Reset mid-run, then a clean run.
        step(0, 1, 4, 0, 16'h0, 0, 0);
        push_one(16'h0011, 0, 0);
        push_one(16'h0022, 0, 0);
        step(1, 0, 0, 0, 16'h0, 0, 0);
        check("rst_mid_valid", 32'(rd_valid), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        step(0, 1, 2, 0, 16'h0, 0, 1);
        push_one(16'h0033, 0, 1);
        push_one(16'h0044, 0, 1);
        idle(1, 5);

        // Saturation on the middle result of three.
        step(0, 1, 3, 0, 16'h0, 0, 0);
        push_one(16'h0101, 0, 0);
        push_one(16'h7FFF, 1, 0);
        push_one(16'h0303, 0, 0);
        idle(1, 6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 250) == 0, ($urandom % 6) == 0, int'($urandom_range(0, 12)),
                 ($urandom % 2) == 0, 16'($urandom), ($urandom % 4) == 0, ($urandom % 3) != 0);
        end
        idle(1, 30);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
